// File: rtl/ram512x1s_fifo_ctrl_pkg.sv
// Parameters shared by the RAM512X1S-based wrappers, and the cycle-mode
// encoding used by the FIFO controller.
package ram512x1s_fifo_ctrl_pkg;

    localparam int RAM_DEPTH = 512;
    localparam int RAM_AW    = 9;
    localparam int LVL_W     = 10;

    typedef enum logic [1:0] {
        MODE_READ   = 2'd0,
        MODE_BYPASS = 2'd1,
        MODE_WRITE  = 2'd2
    } mode_e;

endpackage

// File: rtl/ram512x1s_fifo_ctrl.sv
// 513-entry first-word-fall-through FIFO built from a single-address RAM512X1S bank
// plus a one-entry output register that absorbs the read/write address conflict.
module ram512x1s_fifo_ctrl
    import ram512x1s_fifo_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLR,
    input  logic              IN_VLD,
    output logic              IN_RDY,
    input  logic [WIDTH-1:0]  IN_DATA,
    output logic              OUT_VLD,
    input  logic              OUT_RDY,
    output logic [WIDTH-1:0]  OUT_DATA,
    output logic              RAM_WE,
    output logic [RAM_AW-1:0] RAM_A,
    output logic [WIDTH-1:0]  RAM_D,
    input  logic [WIDTH-1:0]  RAM_O,
    output logic [LVL_W-1:0]  LEVEL
);

    logic [RAM_AW-1:0] rd_ptr;
    logic [RAM_AW-1:0] wr_ptr;
    logic [LVL_W-1:0]  lvl;
    logic              out_vld;
    logic [WIDTH-1:0]  out_data;

    logic  pop;
    logic  slot_free;
    logic  ram_empty;
    logic  ram_full;
    mode_e mode;

    assign pop       = out_vld & OUT_RDY;
    assign slot_free = !out_vld | pop;
    assign ram_empty = (lvl == '0);
    assign ram_full  = (lvl == LVL_W'(RAM_DEPTH));

    // Reading the RAM has priority over accepting input so the output slot
    // always refills from the oldest stored word first.
    always_comb begin
        mode   = MODE_WRITE;
        IN_RDY = 1'b0;
        RAM_WE = 1'b0;
        RAM_A  = rd_ptr;
        if (slot_free) begin
            mode = ram_empty ? MODE_BYPASS : MODE_READ;
        end
        if (mode == MODE_WRITE) begin
            RAM_A = wr_ptr;
        end
        if (RST_N && !CLR) begin
            case (mode)
                MODE_BYPASS: IN_RDY = 1'b1;
                MODE_WRITE: begin
                    IN_RDY = !ram_full;
                    RAM_WE = IN_VLD & !ram_full;
                end
                default: IN_RDY = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            lvl      <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (CLR) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            lvl     <= '0;
            out_vld <= 1'b0;
        end else begin
            case (mode)
                MODE_READ: begin
                    out_data <= RAM_O;
                    out_vld  <= 1'b1;
                    rd_ptr   <= rd_ptr + RAM_AW'(1);
                    lvl      <= lvl - LVL_W'(1);
                end
                MODE_BYPASS: begin
                    out_vld <= IN_VLD;
                    if (IN_VLD) begin
                        out_data <= IN_DATA;
                    end
                end
                default: begin
                    if (RAM_WE) begin
                        wr_ptr <= wr_ptr + RAM_AW'(1);
                        lvl    <= lvl + LVL_W'(1);
                    end
                end
            endcase
        end
    end

    assign OUT_VLD  = out_vld;
    assign OUT_DATA = out_data;
    assign RAM_D    = IN_DATA;
    assign LEVEL    = lvl;

endmodule

// File: tb/tb_ram512x1s_fifo_ctrl.sv
// Self-checking bench for ram512x1s_fifo_ctrl: RAM512X1S bank models, a
// queue-based FIFO model, directed scenarios and a randomized phase.
module tb_ram512x1s_fifo_ctrl;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         CLR = 1'b0;
    logic         IN_VLD = 1'b0;
    logic         IN_RDY;
    logic [W-1:0] IN_DATA = '0;
    logic         OUT_VLD;
    logic         OUT_RDY = 1'b0;
    logic [W-1:0] OUT_DATA;
    logic         RAM_WE;
    logic [8:0]   RAM_A;
    logic [W-1:0] RAM_D;
    logic [W-1:0] RAM_O;
    logic [9:0]   LEVEL;

    ram512x1s_fifo_ctrl #(.WIDTH(W)) dut (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR),
        .IN_VLD(IN_VLD), .IN_RDY(IN_RDY), .IN_DATA(IN_DATA),
        .OUT_VLD(OUT_VLD), .OUT_RDY(OUT_RDY), .OUT_DATA(OUT_DATA),
        .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_D(RAM_D), .RAM_O(RAM_O),
        .LEVEL(LEVEL)
    );

    // Clock / reset block
    always #5 CLK = ~CLK;

    // RAM512X1S bank: one 512x1 array per data bit, sync write, async read.
    for (genvar i = 0; i < W; i++) begin : g_ram
        logic mem [512];
        always @(posedge CLK) begin
            if (RAM_WE) mem[RAM_A] <= RAM_D[i];
        end
        assign RAM_O[i] = mem[RAM_A];
    end

    // Behavioural model: contents of the RAM part, the output slot, and
    // read/write counts; exp_q holds every word owned by the FIFO, oldest first.
    logic [W-1:0] ram_q[$];
    logic [W-1:0] exp_q[$];
    bit           m_out_v;
    logic [W-1:0] m_out_d;
    int           rd_cnt;
    int           wr_cnt;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ram_q.delete();
        exp_q.delete();
        m_out_v = 1'b0;
        m_out_d = '0;
        rd_cnt  = 0;
        wr_cnt  = 0;
    endtask

    // Driver: apply one cycle of inputs, check outputs at the falling edge,
    // advance the model at the rising edge. acc reports whether a push happened.
    task automatic step(input bit vld, input logic [W-1:0] d, input bit rdy,
                        input bit clr, output bit acc);
        bit pop, sf, push, exp_rdy;
        int lvl;
        logic [W-1:0] front;
        IN_VLD  = vld;
        IN_DATA = d;
        OUT_RDY = rdy;
        CLR     = clr;
        @(negedge CLK);
        lvl     = ram_q.size();
        pop     = m_out_v && rdy;
        sf      = !m_out_v || pop;
        exp_rdy = !clr && (sf ? (lvl == 0) : (lvl < 512));
        push    = vld && exp_rdy;
        check("out_vld", 32'(OUT_VLD), 32'(m_out_v));
        check("level", 32'(LEVEL), 32'(lvl));
        if (m_out_v) check("out_data", 32'(OUT_DATA), 32'(m_out_d));
        check("in_rdy", 32'(IN_RDY), 32'(exp_rdy));
        check("ram_we", 32'(RAM_WE), 32'(!sf && push));
        check("ram_a", 32'(RAM_A), 32'(sf ? (rd_cnt % 512) : (wr_cnt % 512)));
        check("ram_d", 32'(RAM_D), 32'(d));
        if (pop) begin
            if (exp_q.size() == 0) begin
                check("pop_nonempty", 32'(0), 32'(1));
            end else begin
                front = exp_q.pop_front();
                check("order", 32'(OUT_DATA), 32'(front));
            end
        end
        if (push) exp_q.push_back(d);
        @(posedge CLK);
        if (clr) begin
            ram_q.delete();
            exp_q.delete();
            rd_cnt  = 0;
            wr_cnt  = 0;
            m_out_v = 1'b0;
        end else if (sf && lvl > 0) begin
            m_out_d = ram_q.pop_front();
            m_out_v = 1'b1;
            rd_cnt++;
        end else if (sf) begin
            m_out_v = vld;
            if (vld) m_out_d = d;
        end else if (push) begin
            ram_q.push_back(d);
            wr_cnt++;
        end
        acc = push;
        #1;
    endtask

    task automatic drain();
        bit acc;
        for (int c = 0; c < 2000; c++) begin
            if (!m_out_v && ram_q.size() == 0) break;
            step(1'b0, '0, 1'b1, 1'b0, acc);
        end
        check("drain_level", 32'(LEVEL), 32'(0));
        check("drain_out_vld", 32'(OUT_VLD), 32'(0));
        check("drain_sb_empty", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        bit acc;
        int idx;
        model_reset();

        // Reset, then idle
        #2;
        check("rst_in_rdy", 32'(IN_RDY), 32'(0));
        check("rst_out_vld", 32'(OUT_VLD), 32'(0));
        check("rst_level", 32'(LEVEL), 32'(0));
        check("rst_ram_we", 32'(RAM_WE), 32'(0));
        check("rst_ram_a", 32'(RAM_A), 32'(0));
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        for (int c = 0; c < 5; c++) step(1'b0, '0, 1'b1, 1'b0, acc);
        check("idle_in_rdy", 32'(IN_RDY), 32'(1));

        // Bypass with consumer always ready
        step(1'b1, 4'h3, 1'b1, 1'b0, acc);
        check("byp_d0", 32'(OUT_DATA), 32'h3);
        check("byp_v0", 32'(OUT_VLD), 32'(1));
        step(1'b1, 4'hA, 1'b1, 1'b0, acc);
        check("byp_d1", 32'(OUT_DATA), 32'hA);
        step(1'b1, 4'h5, 1'b1, 1'b0, acc);
        check("byp_d2", 32'(OUT_DATA), 32'h5);
        check("byp_level", 32'(LEVEL), 32'(0));
        step(1'b0, '0, 1'b1, 1'b0, acc);
        check("byp_done", 32'(OUT_VLD), 32'(0));

        // Fill with consumer stalled: 513 accepted, word 513 waits
        idx = 0;
        for (int c = 0; c < 530; c++) begin
            step(1'b1, W'(idx % 16), 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        check("fill_accepted", 32'(idx), 32'(513));
        check("fill_level", 32'(LEVEL), 32'(512));
        check("fill_out_d", 32'(OUT_DATA), 32'(0));
        #1;
        check("fill_in_rdy", 32'(IN_RDY), 32'(0));
        for (int c = 0; c < 2000; c++) begin
            if (idx == 514 && !m_out_v) break;
            step(idx < 514, W'(idx % 16), 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        check("fill_all_in", 32'(idx), 32'(514));
        drain();

        // Conflict: three words in RAM, one in the output slot, single pop pulse
        for (int c = 0; c < 4; c++) step(1'b1, W'(c + 8), 1'b0, 1'b0, acc);
        check("cfl_level", 32'(LEVEL), 32'(3));
        check("cfl_out_vld", 32'(OUT_VLD), 32'(1));
        IN_VLD = 1'b1;
        OUT_RDY = 1'b1;
        #1;
        check("cfl_in_rdy", 32'(IN_RDY), 32'(0));
        check("cfl_ram_a", 32'(RAM_A), 32'(rd_cnt % 512));
        check("cfl_ram_we", 32'(RAM_WE), 32'(0));
        step(1'b1, 4'hC, 1'b1, 1'b0, acc);
        check("cfl_pulse_level", 32'(LEVEL), 32'(2));
        for (int c = 0; c < 3; c++) step(1'b1, W'(c + 13), 1'b0, 1'b0, acc);
        check("cfl_resume_level", 32'(LEVEL), 32'(5));
        drain();

        // CLR at LEVEL 100
        for (int c = 0; c < 101; c++) step(1'b1, W'($urandom_range(0, 15)), 1'b0, 1'b0, acc);
        check("clr_pre_level", 32'(LEVEL), 32'(100));
        step(1'b1, 4'h1, 1'b0, 1'b1, acc);
        check("clr_level", 32'(LEVEL), 32'(0));
        check("clr_out_vld", 32'(OUT_VLD), 32'(0));
        step(1'b1, 4'h7, 1'b1, 1'b0, acc);
        check("clr_byp_d", 32'(OUT_DATA), 32'h7);
        check("clr_byp_v", 32'(OUT_VLD), 32'(1));
        drain();

        // Asynchronous reset mid-fill at LEVEL 37
        for (int c = 0; c < 38; c++) step(1'b1, W'($urandom_range(0, 15)), 1'b0, 1'b0, acc);
        check("arst_pre_level", 32'(LEVEL), 32'(37));
        #2 RST_N = 1'b0;
        #1;
        check("arst_out_vld", 32'(OUT_VLD), 32'(0));
        check("arst_level", 32'(LEVEL), 32'(0));
        check("arst_in_rdy", 32'(IN_RDY), 32'(0));
        check("arst_ram_we", 32'(RAM_WE), 32'(0));
        model_reset();
        @(posedge CLK);
        #1 RST_N = 1'b1;
        for (int c = 0; c < 40; c++)
            step(1'b1, W'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 1'b0, acc);
        drain();

        // Randomized traffic with occasional flush
        for (int c = 0; c < 1500; c++) begin
            bit r_clr, r_rdy;
            r_clr = ($urandom_range(0, 199) == 0);
            r_rdy = r_clr ? 1'b0 : ($urandom_range(0, 3) != 0);
            step(($urandom_range(0, 2) != 0), W'($urandom_range(0, 15)), r_rdy, r_clr, acc);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
